// File: rtl/core_run_controller.sv
// Purpose : sequences program load into imem, a bounded core run with result signature, then done.
// Latency : start -> LOAD next cycle; N words in >= N cycles; run_cycles RUN cycles; DONE the cycle after.
// Backpres: ld_ready_o high only in LOAD; ld_valid_i bubbles stall the load with no penalty.
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   start_i, prog_len_i, run_cycles_i        : run request, sampled in IDLE/DONE
//   ld_valid_i, ld_ready_o, ld_data_i        : program load stream
//   imem_we_o, imem_addr_o, imem_wdata_o     : instruction-memory write port
//   core_reset_o, core_re_o, mon_result_i    : datapath control and monitored ALU result
//   signature_o, busy_o, done_o, error_o     : run status
module core_run_controller #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CYC_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   prog_len_i,
  input  logic [CYC_W-1:0]  run_cycles_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              core_reset_o,
  output logic              core_re_o,
  input  logic [DATA_W-1:0] mon_result_i,
  output logic [DATA_W-1:0] signature_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  // Word counter is one bit wider than the address so a full DEPTH = 2^ADDR_W
  // program is representable; the address simply wraps after the last word.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CYC_W-1:0]    runc_q, runc_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic                err_q, err_d;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      cyc_q   <= '0;
      runc_q  <= '0;
      sig_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      cyc_q   <= cyc_d;
      runc_q  <= runc_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    cyc_d        = cyc_q;
    runc_d       = runc_q;
    sig_d        = sig_q;
    err_d        = err_q;
    ld_ready_o   = 1'b0;
    imem_we_o    = 1'b0;
    imem_addr_o  = '0;
    imem_wdata_o = '0;
    core_reset_o = 1'b1;
    core_re_o    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done_o = (state_q == S_DONE);
        if (start_i) begin
          // Parameters are latched here so changes while busy have no effect.
          count_d = '0;
          sig_d   = '0;
          len_d   = prog_len_i;
          runc_d  = run_cycles_i;
          if (prog_len_i != '0 && prog_len_i <= DEPTH_L) begin
            state_d = S_LOAD;
            err_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end

      S_LOAD: begin
        ld_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (ld_valid_i) begin
          imem_we_o    = 1'b1;
          imem_addr_o  = count_q[ADDR_W-1:0];
          imem_wdata_o = ld_data_i;
          count_d      = count_q + 1'b1;
          if (count_q + 1'b1 == len_q) begin
            cyc_d   = '0;
            state_d = (runc_q != '0) ? S_RUN : S_DONE;
          end
        end
      end

      S_RUN: begin
        core_reset_o = 1'b0;
        core_re_o    = 1'b1;
        busy_o       = 1'b1;
        // Rotate-left by one then fold in this cycle's ALU result.
        sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ mon_result_i;
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == runc_q - 1'b1) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign signature_o = sig_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_core_run_controller.sv
module tb_core_run_controller;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int CYC_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic [CYC_W-1:0]  run_cycles = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_reset;
  logic              core_re;
  logic [DATA_W-1:0] mon_result = '0;
  logic [DATA_W-1:0] signature;
  logic              busy;
  logic              done;
  logic              error;

  core_run_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CYC_W(CYC_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .prog_len_i(prog_len),
    .run_cycles_i(run_cycles), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_data_i(ld_data), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .core_reset_o(core_reset), .core_re_o(core_re),
    .mon_result_i(mon_result), .signature_o(signature), .busy_o(busy),
    .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Program words and per-cycle ALU results the bench feeds to the DUT.
  logic [DATA_W-1:0] words[$];
  logic [DATA_W-1:0] mons[$];

  // Observations collected by the driver.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int run_cnt, crst_low, rdy_in_run, done_t;

  // Reference signature: rotate-left by one, XOR in each sample, in order.
  function automatic logic [DATA_W-1:0] sig_model(input int n);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = ((s << 1) | (s >> (DATA_W-1))) ^ mons[i];
    return s;
  endfunction

  // Issues one start and then drives the load stream and the ALU result on the
  // bench's own schedule: load is over after the len-th word presented, and the
  // run samples are offered for exactly rc cycles after that. Returns when done
  // is seen, at stop_t, or when the cycle budget runs out (done_t stays -1).
  task automatic drive_run(input int len, input int rc, input int mode,
                           input bit noise, input int stop_t, output int load_end);
    int  sent;
    int  budget;
    bit  v;
    wr_addr.delete(); wr_data.delete();
    run_cnt = 0; crst_low = 0; rdy_in_run = 0; done_t = -1;
    load_end = -1; sent = 0;
    budget = 3 * len + rc + 10;
    @(negedge clk);
    start = 1'b1; prog_len = len[ADDR_W:0]; run_cycles = rc[CYC_W-1:0]; ld_valid = 1'b0;
    @(posedge clk);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (t == stop_t) begin
        start = 1'b0; ld_valid = 1'b0;
        return;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        prog_len   = ADDR_W'($urandom);
        run_cycles = CYC_W'($urandom);
      end
      v = (sent < len) && (mode == 0 || (mode == 1 && (t % 2) == 0) ||
                           (mode == 2 && $urandom_range(0, 2) != 0));
      ld_valid = v ? 1'b1 : (noise && sent >= len) ? 1'($urandom_range(0, 1)) : 1'b0;
      ld_data  = v ? words[sent] : $urandom;
      mon_result = (load_end >= 0 && t - load_end < rc) ? mons[t - load_end] : $urandom;
      #1;
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
      end
      if (core_re) run_cnt++;
      if (!core_reset) crst_low++;
      if (core_re && ld_ready) rdy_in_run++;
      if (done) begin
        done_t = t;
        break;
      end
      @(posedge clk);
      if (v) begin
        sent++;
        if (sent == len) load_end = t + 1;
      end
    end
    start = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; prog_len = 9'd1; run_cycles = 16'd1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (signature !== '0) begin errors++; $display("FAIL reset_signature: got %h expected 0", signature); end
    checks++; if ({ld_ready, imem_we, core_re, error} !== 4'b0) begin errors++; $display("FAIL reset_misc: got %b expected 0000", {ld_ready, imem_we, core_re, error}); end
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({busy, ld_ready} !== 2'b11) begin errors++; $display("FAIL reset_release_start: got %b expected 11", {busy, ld_ready}); end
    start = 1'b0; reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int le;
    logic [DATA_W-1:0] exp_sig;
    words = '{32'h00500093, 32'h00A00113};
    mons  = '{32'd1, 32'd2, 32'd3};
    drive_run(2, 3, 0, 1'b0, -1, le);
    exp_sig = sig_model(3);
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d expected 2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== words[0]) begin errors++; $display("FAIL basic_wr0: got %h/%h expected 00/%h", wr_addr[0], wr_data[0], words[0]); end
      checks++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== words[1]) begin errors++; $display("FAIL basic_wr1: got %h/%h expected 01/%h", wr_addr[1], wr_data[1], words[1]); end
    end
    checks++; if (run_cnt !== 3 || crst_low !== 3) begin errors++; $display("FAIL basic_run_cycles: got %0d/%0d expected 3/3", run_cnt, crst_low); end
    checks++; if (done_t !== 5) begin errors++; $display("FAIL basic_done_time: got %0d expected 5", done_t); end
    checks++; if (signature !== exp_sig) begin errors++; $display("FAIL basic_signature: got %h expected %h", signature, exp_sig); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b expected 0", error); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({done, core_reset, busy} !== 3'b110 || signature !== exp_sig) begin errors++; $display("FAIL basic_hold: got %b sig %h expected 110 sig %h", {done, core_reset, busy}, signature, exp_sig); end
  endtask

  task automatic test_bubbles();
    int le, bad;
    logic [DATA_W-1:0] exp_sig;
    words.delete(); mons.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    for (int i = 0; i < 2; i++) mons.push_back($urandom);
    drive_run(4, 2, 1, 1'b0, -1, le);
    exp_sig = sig_model(2);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 4; i++)
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== words[i]) bad++;
    checks++; if (wr_addr.size() !== 4 || bad != 0) begin errors++; $display("FAIL bubbles_writes: got %0d writes %0d wrong expected 4 writes 0 wrong", wr_addr.size(), bad); end
    checks++; if (done_t !== 9) begin errors++; $display("FAIL bubbles_done_time: got %0d expected 9", done_t); end
    checks++; if (run_cnt !== 2 || signature !== exp_sig) begin errors++; $display("FAIL bubbles_run: got %0d cycles sig %h expected 2 cycles sig %h", run_cnt, signature, exp_sig); end
  endtask

  task automatic test_illegal();
    int le;
    int lens[2];
    lens[0] = 0; lens[1] = DEPTH + 1;
    for (int k = 0; k < 2; k++) begin
      words.delete(); mons.delete();
      for (int i = 0; i < 4; i++) mons.push_back($urandom);
      drive_run(lens[k], 4, 0, 1'b0, -1, le);
      checks++; if (done_t !== 0 || error !== 1'b1) begin errors++; $display("FAIL illegal_%0d_done_error: got t=%0d err=%b expected t=0 err=1", lens[k], done_t, error); end
      checks++; if (wr_addr.size() !== 0 || crst_low !== 0) begin errors++; $display("FAIL illegal_%0d_activity: got %0d writes %0d run expected 0/0", lens[k], wr_addr.size(), crst_low); end
      checks++; if (signature !== '0) begin errors++; $display("FAIL illegal_%0d_signature: got %h expected 0", lens[k], signature); end
    end
  endtask

  task automatic test_zero_run();
    int le;
    words = '{32'h12345678};
    mons.delete();
    drive_run(1, 0, 0, 1'b0, -1, le);
    checks++; if (wr_addr.size() !== 1 || wr_data[0] !== words[0]) begin errors++; $display("FAIL zero_run_write: got %0d writes expected 1", wr_addr.size()); end
    checks++; if (crst_low !== 0 || done_t !== 1) begin errors++; $display("FAIL zero_run_core: got low=%0d t=%0d expected 0/1", crst_low, done_t); end
    checks++; if (signature !== '0 || error !== 1'b0) begin errors++; $display("FAIL zero_run_sig_err: got %h/%b expected 0/0", signature, error); end
  endtask

  task automatic test_reset_mid_run();
    int le;
    logic [DATA_W-1:0] exp_sig;
    words = '{32'h0000_0013};
    mons.delete();
    for (int i = 0; i < 5; i++) mons.push_back($urandom | 32'h1);
    drive_run(1, 5, 0, 1'b0, 2, le);
    reset_n = 1'b0;
    #1;
    checks++; if ({core_reset, busy, core_re, done, ld_ready} !== 5'b10000) begin errors++; $display("FAIL midrun_async: got %b expected 10000", {core_reset, busy, core_re, done, ld_ready}); end
    checks++; if (signature !== '0) begin errors++; $display("FAIL midrun_signature: got %h expected 0", signature); end
    #1 reset_n = 1'b1;
    mons = '{32'hDEADBEEF};
    drive_run(1, 1, 0, 1'b0, -1, le);
    exp_sig = sig_model(1);
    checks++; if (signature !== exp_sig || run_cnt !== 1) begin errors++; $display("FAIL midrun_rerun: got %h/%0d expected %h/1", signature, run_cnt, exp_sig); end
  endtask

  task automatic test_random();
    int le, len, rc, bad;
    logic [DATA_W-1:0] exp_sig;
    for (int it = 0; it < 6; it++) begin
      len = (it == 3) ? DEPTH : $urandom_range(1, 24);
      rc  = $urandom_range(1, 20);
      words.delete(); mons.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      for (int i = 0; i < rc; i++) mons.push_back($urandom);
      drive_run(len, rc, 2, 1'b1, -1, le);
      exp_sig = sig_model(rc);
      bad = 0;
      for (int i = 0; i < wr_addr.size() && i < len; i++)
        if (wr_addr[i] !== ADDR_W'(i % DEPTH) || wr_data[i] !== words[i]) bad++;
      checks++; if (wr_addr.size() !== len || bad != 0) begin errors++; $display("FAIL random%0d_writes: got %0d writes %0d wrong expected %0d writes 0 wrong", it, wr_addr.size(), bad, len); end
      checks++; if (run_cnt !== rc || rdy_in_run !== 0) begin errors++; $display("FAIL random%0d_run: got %0d cycles ready=%0d expected %0d/0", it, run_cnt, rdy_in_run, rc); end
      checks++; if (done_t !== le + rc) begin errors++; $display("FAIL random%0d_done_time: got %0d expected %0d", it, done_t, le + rc); end
      checks++; if (signature !== exp_sig || error !== 1'b0) begin errors++; $display("FAIL random%0d_signature: got %h/%b expected %h/0", it, signature, error, exp_sig); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_illegal();
    test_zero_run();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_controller.md
# core_run_controller

Synthesizable sequencer that replaces hand-driven bench stimulus around `final_data_path`. It streams a program into instruction memory over a valid/ready load port while holding the core in reset. It then releases the core for a programmed number of cycles and folds the per-cycle ALU result into a rotate-XOR signature. It finishes by re-asserting core reset and flagging done, so a run is repeatable and self-checking in simulation and on FPGA.

## Interface
Parameters:
- `DATA_W`, 32, instruction/result width
- `ADDR_W`, 8, instruction-memory address width
- `DEPTH`, 256, max program words (≤ 2^ADDR_W)
- `CYC_W`, 16, run-cycle counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  level; sampled in IDLE/DONE only
- `prog_len`  in  ADDR_W+1  words to load, legal 1..DEPTH, sampled with start
- `run_cycles`  in  CYC_W  core cycles to run, sampled with start
- `ld_valid`  in  1  load word valid
- `ld_ready`  out  1  controller accepts load word
- `ld_data`  in  DATA_W  load word
- `imem_we`  out  1  instruction-memory write enable
- `imem_addr`  out  ADDR_W  write address
- `imem_wdata`  out  DATA_W  write data
- `core_reset`  out  1  active-high reset to datapath
- `core_re`  out  1  datapath read enable
- `mon_result`  in  DATA_W  datapath ALUResult
- `signature`  out  DATA_W  accumulated result signature
- `busy`  out  1  LOAD or RUN
- `done`  out  1  run finished
- `error`  out  1  illegal prog_len on last start

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE, start=1:
  - prog_len in 1..DEPTH → LOAD; word count=0, signature=0, error=0.
  - Otherwise → DONE with error=1, signature=0, no load.
- LOAD:
  - ld_ready=1, core_reset=1.
  - On ld_valid&&ld_ready: combinational imem_we=1, imem_addr=count, imem_wdata=ld_data; count++.
  - On acceptance of word prog_len-1: → RUN if run_cycles≠0, else → DONE. Cycle count=0.
- RUN:
  - core_reset=0, core_re=1, ld_ready=0; ld_valid ignored.
  - Each cycle: signature ← {signature[DATA_W-2:0], signature[DATA_W-1]} ^ mon_result; cycles++.
  - After run_cycles updates → DONE.
- DONE:
  - done=1, core_reset=1, core_re=0, signature held.
  - start=1 → behaves as from IDLE: re-load, done cleared.
- start asserted while busy: ignored; parameters latched at accepted start are used.
- Width rules: signature update is modulo DATA_W (no carry). count compares at ADDR_W+1 bits, so prog_len=DEPTH=2^ADDR_W is legal and address wraps only after the final word.

## Timing
- Reset values:
  - state=IDLE
  - ld_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - core_reset=1, core_re=0
  - signature=0, busy=0, done=0, error=0
- Async reset mid-LOAD or mid-RUN: outputs above immediately; partial memory contents are not cleared.
- start sampled at edge 0 → LOAD visible after edge 0; first word can be accepted in the cycle after.
- Back-to-back ld_valid: one word per cycle. N words take N cycles minimum; bubbles on ld_valid stall without penalty.
- core_reset deasserts in the cycle after the last accepted word. It re-asserts in the cycle after the run_cycles-th signature update.
- mon_result is sampled at each rising edge while in RUN, so exactly run_cycles samples are taken.
- done/error rise in the same cycle as DONE entry and remain until the next accepted start or reset.
- busy=1 exactly in LOAD and RUN.

## Test plan
- Reset held low 3 cycles with start=1 → core_reset=1, busy=0, done=0, signature=0. Release reset → IDLE entered and start accepted on next edge.
- prog_len=2, run_cycles=3, words 0x00500093, 0x00A00113 back-to-back; mon_result 1, 2, 3 in RUN → imem writes at addr 0,1; exactly 3 RUN cycles; signature=0x00000003; done=1.
- prog_len=4 with ld_valid toggling 1,0,1,0,… → imem_we only on valid cycles, addresses 0..3 in order, RUN entered after the 4th accepted word.
- prog_len=0, then separately prog_len=DEPTH+1 → immediate DONE, error=1, no imem_we, core_reset stays 1.
- prog_len=1, run_cycles=0 → one write, then DONE directly; core_reset never deasserts; signature=0.
- Reset asserted in RUN cycle 2 of 5 → core_reset=1 and state IDLE without a clock. New start with run_cycles=1 and mon_result=0xDEADBEEF → signature=0xDEADBEEF.
